// File: rtl/cpu_muldiv_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : cpu_muldiv_pkg                                               |
// | Purpose : Shared constants for the RV32M multiply/divide unit:         |
// |           funct3 op encodings, FSM state encodings, step count.        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package cpu_muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Iterations of the shared shift datapath
  localparam int MD_STEPS = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } md_state_e;

endpackage : cpu_muldiv_pkg
`default_nettype wire

// File: rtl/cpu_muldiv_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : cpu_muldiv_unit_if                                         |
// | Purpose   : Request/response bundle between the CPU and the mul/div    |
// |             unit.                                                      |
// | Signals   : start, op[2:0], a, b, kill  (CPU -> unit)                  |
// |             busy, done, result          (unit -> CPU)                  |
// | Modports  : master = CPU side, slave = mul/div unit side               |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface cpu_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, kill,
    output busy, done, result
  );
endinterface : cpu_muldiv_unit_if
`default_nettype wire

// File: rtl/cpu_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cpu_muldiv_unit                                              |
// | Purpose : Iterative RV32M multiply/divide. One shared 32-step shift    |
// |           datapath runs shift-add multiply (LSB first) or restoring    |
// |           divide (MSB first) on operand magnitudes; a FIX cycle        |
// |           applies sign correction and selects the output word.         |
// | Ports   : clk    - rising-edge clock                                   |
// |           rst_n  - asynchronous active-low reset                       |
// |           md_if  - slave side of cpu_muldiv_unit_if                    |
// |                    (start/op/a/b/kill in, busy/done/result out)        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module cpu_muldiv_unit
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_muldiv_unit_if.slave  md_if
);

  localparam int               CW       = $clog2(MD_STEPS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(MD_STEPS - 1);

  md_state_e         state_q;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  // [2X:X] = product high / 33-bit remainder, [X-1:0] = multiplier / quotient
  logic [2*XLEN:0]   acc_q;
  logic [XLEN-1:0]   bval_q;   // raw b; magnitude is applied in the adder
  logic              bsub_q;   // b is a negative signed operand
  logic              neg_q;    // final result needs negation
  logic [XLEN-1:0]   result_q;
  logic              done_q;
  logic              busy_q;

  assign md_if.busy   = busy_q;
  assign md_if.done   = done_q;
  assign md_if.result = result_q;

  // ---------------- operand sign decode (IDLE) ----------------
  logic w_sa, w_sb, w_a_neg, w_b_neg, w_div_zero;

  assign w_sa = (md_if.op == MD_MULH) || (md_if.op == MD_MULHSU) ||
                (md_if.op == MD_DIV)  || (md_if.op == MD_REM);
  assign w_sb = (md_if.op == MD_MULH) || (md_if.op == MD_DIV) ||
                (md_if.op == MD_REM);
  assign w_a_neg    = w_sa & md_if.a[XLEN-1];
  assign w_b_neg    = w_sb & md_if.b[XLEN-1];
  assign w_div_zero = md_if.op[2] && (md_if.b == '0);

  // ---------------- iteration datapath (RUN) ----------------
  logic [XLEN-1:0] w_hi, w_lo;
  assign w_hi = acc_q[2*XLEN-1:XLEN];
  assign w_lo = acc_q[XLEN-1:0];

  // Multiply: adding |b| for a negative b is done as subtracting b
  // sign-extended to 33 bits, so no separate negation of b is needed.
  logic [XLEN:0] w_mul_sum;
  always_comb begin
    w_mul_sum = {1'b0, w_hi};
    if (acc_q[0]) begin
      if (bsub_q) w_mul_sum = {1'b0, w_hi} - {1'b1, bval_q};
      else        w_mul_sum = {1'b0, w_hi} + {1'b0, bval_q};
    end
  end

  // Divide: trial subtract of |b| from the shifted remainder. The extra
  // top bit keeps the difference's sign exact for any 32-bit divisor.
  logic [XLEN+1:0] w_div_sh, w_div_diff;
  logic            w_qbit;
  logic [XLEN:0]   w_rem_next;
  assign w_div_sh   = {acc_q[2*XLEN:XLEN], acc_q[XLEN-1]};
  assign w_div_diff = bsub_q ? (w_div_sh + {2'b11, bval_q})
                             : (w_div_sh - {2'b00, bval_q});
  assign w_qbit     = ~w_div_diff[XLEN+1];
  assign w_rem_next = w_qbit ? w_div_diff[XLEN:0] : w_div_sh[XLEN:0];

  logic [2*XLEN:0] w_acc_step;
  assign w_acc_step = op_q[2] ? {w_rem_next, w_lo[XLEN-2:0], w_qbit}
                              : {1'b0, w_mul_sum, w_lo[XLEN-1:1]};

  // ---------------- shared negate incrementer ----------------
  // IDLE: |a| = ~a + 1.  FIX: ~word + 1, except for a high product word,
  // where the carry out of the low word's negation is (lo == 0).
  logic            w_is_mulh;
  logic [XLEN-1:0] w_word, w_inc_in, w_inc, w_fix_res, w_a_mag;
  logic            w_inc_cin;

  assign w_is_mulh = !op_q[2] && (op_q != MD_MUL);
  assign w_word    = op_q[2] ? (op_q[1] ? w_hi : w_lo)
                             : ((op_q == MD_MUL) ? w_lo : w_hi);

  always_comb begin
    w_inc_in  = ~w_word;
    w_inc_cin = 1'b1;
    if (state_q == S_IDLE) begin
      w_inc_in  = ~md_if.a;
      w_inc_cin = 1'b1;
    end else if (w_is_mulh) begin
      w_inc_in  = ~w_hi;
      w_inc_cin = (w_lo == '0);
    end
  end

  assign w_inc     = w_inc_in + {{(XLEN-1){1'b0}}, w_inc_cin};
  assign w_fix_res = neg_q ? w_inc : w_word;
  assign w_a_mag   = w_a_neg ? w_inc : md_if.a;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      bval_q   <= '0;
      bsub_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_if.start && !md_if.kill) begin
            op_q   <= md_if.op;
            bval_q <= md_if.b;
            bsub_q <= w_b_neg;
            // remainder follows the dividend; everything else the xor
            neg_q  <= (md_if.op[2] && md_if.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            cnt_q  <= '0;
            acc_q  <= {{(XLEN+1){1'b0}}, w_a_mag};
            busy_q <= 1'b1;
            if (w_div_zero) begin
              result_q <= md_if.op[1] ? md_if.a : '1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (md_if.kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= w_acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
        end

        S_FIX: begin
          if (md_if.kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            result_q <= w_fix_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule : cpu_muldiv_unit
`default_nettype wire

// File: tb/tb_cpu_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_cpu_muldiv_unit                                           |
// | Purpose : Directed self-checking bench for cpu_muldiv_unit.            |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_cpu_muldiv_unit;
  import cpu_muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cpu_muldiv_unit_if #(.XLEN(32)) bus ();

  cpu_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; returns the result seen with done and the latency in
  // cycles (1 = done right after the start edge). Operands are scrambled
  // after the start edge. Leaves the unit back in IDLE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output int lat);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    res = bus.result;
    step();
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    do_op(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7x-3 got %h want ffffffeb", r); end
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL mul_latency got %0d want 34", lat); end
    do_op(MD_MULH, 32'h0000_0007, 32'hFFFF_FFFD, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_7x-3 got %h want ffffffff", r); end
    do_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max got %h want fffffffe", r); end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2 got %h want fffffffd", r); end
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
    do_op(MD_REM, 32'hFFFF_FFF9, 32'h0000_0002, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_-7/2 got %h want ffffffff", r); end
    do_op(MD_DIVU, 32'h8000_0000, 32'h0000_0003, r, lat);
    n_tests++;
    if (r !== 32'h2AAA_AAAA) begin n_fail++; $display("FAIL divu_8000_0000/3 got %h want 2aaaaaaa", r); end
    do_op(MD_REMU, 32'h8000_0000, 32'h0000_0003, r, lat);
    n_tests++;
    if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL remu_8000_0000/3 got %h want 2", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int lat;
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_tests++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow got %h want 80000000", r); end
    do_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_tests++;
    if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL rem_overflow got %h want 0", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int lat;
    do_op(MD_DIV, 32'h0000_0005, 32'h0000_0000, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero got %h want ffffffff", r); end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL div_by_zero_latency got %0d want 1", lat); end
    do_op(MD_REMU, 32'h0000_0005, 32'h0000_0000, r, lat);
    n_tests++;
    if (r !== 32'h0000_0005) begin n_fail++; $display("FAIL remu_by_zero got %h want 5", r); end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL remu_by_zero_latency got %0d want 1", lat); end
  endtask

  task automatic test_back_to_back();
    int          n_done;
    int          first_k;
    logic        prev_done;
    logic        busy34, busy35;
    logic [31:0] r33;
    n_done    = 0;
    first_k   = -1;
    prev_done = 1'b0;
    busy34    = 1'bx;
    busy35    = 1'bx;
    r33       = 'x;
    bus.op    = MD_MUL;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_k < 0) begin first_k = k; r33 = bus.result; end
        n_tests++;
        if (prev_done === 1'b1) begin n_fail++; $display("FAIL b2b_done_twice at k=%0d", k); end
      end
      prev_done = bus.done;
      if (k == 34) busy34 = bus.busy;
      if (k == 35) busy35 = bus.busy;
    end
    bus.start = 1'b0;
    n_tests++;
    if (n_done !== 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", n_done); end
    n_tests++;
    if (first_k !== 33) begin n_fail++; $display("FAIL b2b_done_edge got %0d want 33", first_k); end
    n_tests++;
    if (r33 !== 32'd15) begin n_fail++; $display("FAIL b2b_result got %h want f", r33); end
    n_tests++;
    if (busy34 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap busy got %b want 0", busy34); end
    n_tests++;
    if (busy35 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept busy got %b want 1", busy35); end
    // flush the second operation
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_flush busy got %b want 0", bus.busy); end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat;
    int seen_done;
    // start and kill in the same cycle: not accepted
    bus.op = MD_MUL; bus.a = 32'd1; bus.b = 32'd1;
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_blocks_start busy got %b want 0", bus.busy); end
    // kill at RUN counter 10; prior result is 15 from the back-to-back op
    bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", bus.busy); end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done++;
      step();
    end
    n_tests++;
    if (seen_done !== 0) begin n_fail++; $display("FAIL kill_no_done got %0d pulses want 0", seen_done); end
    n_tests++;
    if (bus.result !== 32'd15) begin n_fail++; $display("FAIL kill_result_held got %h want f", bus.result); end
    do_op(MD_DIVU, 32'd100, 32'd7, r, lat);
    n_tests++;
    if (r !== 32'd14) begin n_fail++; $display("FAIL kill_restart got %h want e", r); end
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL kill_restart_latency got %0d want 34", lat); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int lat;
    bus.op = MD_MUL; bus.a = 32'd6; bus.b = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", bus.done); end
    n_tests++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL arst_result got %h want 0", bus.result); end
    #1 rst_n = 1'b1;
    step();
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_discarded busy got %b want 0", bus.busy); end
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, r, lat);
    n_tests++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_-1x2 got %h want ffffffff", r); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    test_mul();
    test_div();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cpu_muldiv_unit
`default_nettype wire

// File: doc/cpu_muldiv_unit.md
# cpu_muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the CPU register file: it consumes the two source operands read on `rd1`/`rd2` and produces the 32-bit value written back via `wd3`. A single shared 32-step datapath executes all eight M-extension operations. `busy` stalls the PC and register-file write until `done` pulses with the result.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `a`  in  32  operand rs1 (from `rd1`)
- `b`  in  32  operand rs2 (from `rd2`)
- `kill`  in  1  abort the in-flight operation (pipeline flush)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; `result` valid in that cycle
- `result`  out  32  last completed result; held until the next `done`

## Operation
- Reset (async, `rst_n`=0): state IDLE; `busy`=0, `done`=0, `result`=0, counter=0, all internal registers 0. Reset asserted mid-operation discards the operation with no `done`.
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start`=1: latch `op`. Signed ops (MULH/DIV/REM: both operands; MULHSU: `a` only) latch magnitudes and record the sign flags. Counter := 0. Next state:
  - divide op with `b`==0: DONE. `result` = 0xFFFFFFFF for DIV/DIVU; `a` unmodified for REM/REMU.
  - otherwise: RUN.
- RUN, multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Remainder register is 33 bits wide so the trial subtract never overflows.
- RUN lasts exactly 32 cycles (counter 0..31). After counter 31, next state is FIX.
- FIX: apply sign correction (two's-complement negate).
  - Product: negated when the operand signs differ.
  - Quotient: negated when the signs differ.
  - Remainder: takes the sign of the dividend.
- FIX then selects the output word: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits. Registers it into `result`, then goes to DONE.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF) needs no special path: quotient 0x80000000, remainder 0.
- DONE: `done`=1 for exactly this cycle, then IDLE. `start` is ignored in DONE.
- `start` while `busy`: ignored. No queueing.
- `kill` (any non-IDLE state): next state IDLE. No `done`, `result` unchanged. `kill` wins over `done` when both happen in the same cycle. `kill` in IDLE is a no-op, and `start` is not accepted in a cycle with `kill`=1.
- Operands `a`, `b`, `op` may change freely after the start edge.

## Timing
- Start accepted at edge E0.
- Normal path: RUN spans the cycles after edges E0..E31, FIX follows E32, DONE follows E33. Start-to-`done` latency is 34 cycles. Back in IDLE after E34.
- Divide-by-zero path: DONE follows E0. Latency is 1 cycle.
- Earliest back-to-back start is the cycle after DONE, giving throughput of 1 op per 35 cycles.
- `busy` goes high in the cycle after the accepted start and stays high through DONE.
- `busy` and `done` are register outputs with no combinational path from inputs. The CPU combines them with its own decode to form the stall.

## Structure
- Shared package `cpu_muldiv_pkg` holds:
  - op encoding constants (`MD_MUL`..`MD_REMU`);
  - state encoding localparams;
  - `MD_STEPS` = 32.
- One module. No sub-module is needed: multiply and divide share the accumulator, counter and negate logic.
- Negation is a single 32-bit incrementer shared by the operand-magnitude step and the FIX step.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` 34 cycles after start, `result`=0xFFFFFFEB. MULH same operands → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF. DIVU 0x80000000 / 3 → 0x2AAAAAAA; REMU same operands → 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0. DIV 5 / 0 → 0xFFFFFFFF with `done` 1 cycle after start. REMU 5 / 0 → 5.
- Pulse `start` every cycle for 40 cycles → exactly one op completes at cycle 34; the next is accepted at cycle 35; `done` is never high two cycles in a row.
- Assert `kill` at RUN counter 10 → no `done`, `result` keeps its prior value, `busy`=0 on the next cycle, and a new start completes normally.
- Drop `rst_n` at RUN counter 20 → `busy`/`done`/`result` read 0 immediately (asynchronously). After release, MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
